dmux_stream: RTL and testbench

Parametrised N-way streaming demultiplexer: routes a WIDTH-bit word stream with valid/ready handshake from one input port to one of N output channels chosen by `in_sel`. It is the registered, back-pressured successor of the combinational 4-way demux, used to steer CPU/bus words to peripheral or memory channels. Each output has a single-entry register slot. Out-of-range selects are dropped and counted.

---
 rtl/dmux_pkg.sv | 12 +
 rtl/dmux_slot.sv | 31 +++
 rtl/dmux_stream.sv | 114 +++++++++++
 tb/tb_dmux_stream.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the dmux_stream demultiplexer: drop counter width and
// packet-lock FSM state encoding.
package dmux_pkg;

    localparam int unsigned DROP_W = 8;

    typedef enum logic {
        DMUX_IDLE = 1'b0,
        DMUX_LOCK = 1'b1
    } dmux_state_e;

endpackage

// File: rtl/dmux_slot.sv
// One-entry output register slot: holds a word plus its last flag until the
// consumer drains it. A load in the same cycle as a drain keeps the slot full.
module dmux_slot #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
            last <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= in_data;
            last <= in_last;
        end else if (full && drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// N-way registered streaming demultiplexer with per-channel one-entry slots and
// a saturating drop counter for out-of-range selects.
// Optional packet lock FSM enabled by defining DMUX_PKT_LOCK_EN.
module dmux_stream
    import dmux_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    output logic [N-1:0]       out_last,
    input  logic [N-1:0]       out_ready,
    output logic               drop_pulse,
    output logic [DROP_W-1:0]  drop_count
);

    logic [SEL_W-1:0] esel;
    logic             route_ok;
    logic             sel_free;
    logic             accept;
    logic [N-1:0]     load;

`ifdef DMUX_PKT_LOCK_EN
    dmux_state_e      state_q;
    dmux_state_e      state_d;
    logic [SEL_W-1:0] lock_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMUX_IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && (state_q == DMUX_IDLE)) begin
                lock_q <= in_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DMUX_IDLE: if (accept && !in_last) state_d = DMUX_LOCK;
            DMUX_LOCK: if (accept && in_last)  state_d = DMUX_IDLE;
            default:   state_d = DMUX_IDLE;
        endcase
    end

    // Locked packets keep their first beat's select, even when it is out of range.
    assign esel = (state_q == DMUX_LOCK) ? lock_q : in_sel;
`else
    assign esel = in_sel;
`endif

    assign route_ok = (32'(esel) < N);

    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (SEL_W'(k) == esel) begin
                sel_free = !out_valid[k] || out_ready[k];
            end
        end
    end

    // Drop beats are always taken; nothing is accepted while reset is asserted.
    assign in_ready = rst_n && (!route_ok || sel_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < int'(N); k++) begin
            load[k] = accept && (SEL_W'(k) == esel);
        end
    end

    for (genvar k = 0; k < int'(N); k++) begin : g_slot
        dmux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load[k]),
            .drain  (out_ready[k]),
            .in_data(in_data),
            .in_last(in_last),
            .full   (out_valid[k]),
            .data   (out_data[k*WIDTH +: WIDTH]),
            .last   (out_last[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= accept && !route_ok;
            if (accept && !route_ok && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Directed self-checking bench for dmux_stream: a 4-channel instance for routing
// and back-pressure, and a 3-channel instance for out-of-range drops.
module tb_dmux_stream;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic [1:0]     in_sel = '0;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_last;
    logic [3:0]     out_ready = '0;
    logic           drop_pulse;
    logic [7:0]     drop_count;

    // 3-channel instance
    logic [W-1:0]   d3_in_data = '0;
    logic           d3_in_valid = 1'b0;
    logic           d3_in_last = 1'b0;
    logic [1:0]     d3_in_sel = '0;
    logic           d3_in_ready;
    logic [3*W-1:0] d3_out_data;
    logic [2:0]     d3_out_valid;
    logic [2:0]     d3_out_last;
    logic [2:0]     d3_out_ready = '1;
    logic           d3_drop_pulse;
    logic [7:0]     d3_drop_count;

    int checks = 0;
    int errors = 0;

    dmux_stream #(.WIDTH(W), .N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_sel(in_sel),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    dmux_stream #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_last(d3_in_last), .in_sel(d3_in_sel),
        .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_last(d3_out_last),
        .out_ready(d3_out_ready),
        .drop_pulse(d3_drop_pulse), .drop_count(d3_drop_count)
    );

    function automatic logic [W-1:0] ch(input logic [4*W-1:0] bus, input int k);
        return bus[k*W +: W];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        d3_in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || d3_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b/%b want 0/0", in_ready, d3_in_ready);
        end
        checks++;
        if (out_valid !== 4'b0 || out_last !== 4'b0 || out_data !== '0 || drop_pulse !== 1'b0
            || drop_count !== 8'd0 || d3_drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_outputs got v=%b l=%b d=%h dc=%0d want zeros",
                                out_valid, out_last, out_data, drop_count);
        end
        in_valid = 1'b0;
        d3_in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_route();
        out_ready = 4'b1111;
        in_sel = 2'd2; in_data = 16'hBEEF; in_last = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL route_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        in_sel = 2'd0; in_data = 16'h1234; in_last = 1'b1;
        checks++;
        if (out_valid !== 4'b0100 || ch(out_data, 2) !== 16'hBEEF || out_last !== 4'b0000) begin
            errors++; $display("FAIL route_ch2 got v=%b d=%h l=%b want 0100 beef 0000",
                                out_valid, ch(out_data, 2), out_last);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0001 || ch(out_data, 0) !== 16'h1234 || out_last !== 4'b0001) begin
            errors++; $display("FAIL route_ch0 got v=%b d=%h l=%b want 0001 1234 0001",
                                out_valid, ch(out_data, 0), out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000 || ch(out_data, 2) !== 16'hBEEF || drop_count !== 8'd0) begin
            errors++; $display("FAIL route_drain got v=%b d2=%h dc=%0d want 0000 beef 0",
                                out_valid, ch(out_data, 2), drop_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_sel = 2'd1; in_data = 16'hAAAA; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_data = 16'hBBBB; in_last = 1'b1;
        #1;
        checks++;
        if (out_valid[1] !== 1'b1 || ch(out_data, 1) !== 16'hAAAA || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall got v1=%b d=%h rdy=%b want 1 aaaa 0",
                                out_valid[1], ch(out_data, 1), in_ready);
        end
        @(negedge clk);
        checks++;
        if (ch(out_data, 1) !== 16'hAAAA || out_last[1] !== 1'b0) begin
            errors++; $display("FAIL bp_hold got d=%h l=%b want aaaa 0", ch(out_data, 1), out_last[1]);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b1 || ch(out_data, 1) !== 16'hBBBB || out_last[1] !== 1'b1) begin
            errors++; $display("FAIL bp_refill got v1=%b d=%h l=%b want 1 bbbb 1",
                                out_valid[1], ch(out_data, 1), out_last[1]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_empty got v=%b want 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b1110;
        in_sel = 2'd0; in_data = 16'h0F0F; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_sel = 2'd3; in_data = 16'h3000;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready beat %0d got %b want 1", i, in_ready);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 4'b1001 || ch(out_data, 3) !== 16'h3000 + W'(i - 1)
                || ch(out_data, 0) !== 16'h0F0F) begin
                errors++; $display("FAIL b2b_beat %0d got v=%b d3=%h d0=%h want 1001 %h 0f0f",
                                    i, out_valid, ch(out_data, 3), ch(out_data, 0), 16'h3000 + W'(i - 1));
            end
            in_data = 16'h3000 + W'(i);
        end
        in_valid = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL b2b_empty got v=%b want 0000", out_valid);
        end
    endtask

    task automatic test_drop();
        int pulses;
        pulses = 0;
        d3_in_sel = 2'd3; d3_in_data = 16'hDEAD; d3_in_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            #1;
            if (d3_in_ready !== 1'b1) begin
                checks++; errors++; $display("FAIL drop_ready beat %0d got %b want 1", i, d3_in_ready);
            end
            @(negedge clk);
            if (d3_drop_pulse === 1'b1) pulses++;
            if (i == 1 || i == 255 || i == 256) begin
                checks++;
                if (d3_drop_count !== ((i > 255) ? 8'd255 : 8'(i))) begin
                    errors++; $display("FAIL drop_count_at %0d got %0d want %0d", i, d3_drop_count,
                                        (i > 255) ? 255 : i);
                end
            end
            if (d3_out_valid !== 3'b000) begin
                checks++; errors++; $display("FAIL drop_out_valid beat %0d got %b want 000", i, d3_out_valid);
            end
        end
        d3_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pulses != 300 || d3_drop_count !== 8'd255 || d3_drop_pulse !== 1'b0) begin
            errors++; $display("FAIL drop_total got pulses=%0d dc=%0d p=%b want 300 255 0",
                                pulses, d3_drop_count, d3_drop_pulse);
        end
        d3_in_sel = 2'd1; d3_in_data = 16'h5151; d3_in_valid = 1'b1;
        @(negedge clk);
        d3_in_valid = 1'b0;
        checks++;
        if (d3_out_valid !== 3'b010 || d3_out_data[W +: W] !== 16'h5151 || d3_drop_pulse !== 1'b0) begin
            errors++; $display("FAIL drop_inrange got v=%b d=%h p=%b want 010 5151 0",
                                d3_out_valid, d3_out_data[W +: W], d3_drop_pulse);
        end
    endtask

`ifdef DMUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [1:0] sels [3];
        sels[0] = 2'd1; sels[1] = 2'd3; sels[2] = 2'd3;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sel = sels[i]; in_data = 16'hC000 + W'(i); in_last = (i == 2);
            @(negedge clk);
            checks++;
            if (out_valid !== 4'b0010 || ch(out_data, 1) !== 16'hC000 + W'(i)
                || out_last[1] !== (i == 2)) begin
                errors++; $display("FAIL lock_beat %0d got v=%b d=%h l=%b want 0010 %h %b",
                                    i, out_valid, ch(out_data, 1), out_last[1], 16'hC000 + W'(i), i == 2);
            end
        end
        in_sel = 2'd2; in_data = 16'hD000; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0100 || ch(out_data, 2) !== 16'hD000) begin
            errors++; $display("FAIL lock_next got v=%b d=%h want 0100 d000", out_valid, ch(out_data, 2));
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        in_valid = 1'b1;
        in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i); in_data = 16'hE000 + W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1111) begin
            errors++; $display("FAIL mid_fill got v=%b want 1111", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0 || out_data !== '0 || out_last !== 4'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%b d=%h l=%b rdy=%b want zeros",
                                out_valid, out_data, out_last, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'b1111;
        in_sel = 2'd2; in_data = 16'h2222; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b0100 || ch(out_data, 2) !== 16'h2222) begin
            errors++; $display("FAIL mid_after got v=%b d=%h want 0100 2222", out_valid, ch(out_data, 2));
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_back_to_back();
        test_drop();
`ifdef DMUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
